riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load/store unit between the multi-cycle datapath's memory stage and a wait-state data-memory bus with a valid/ready handshake. It takes one load or store request per access and aligns store data into byte lanes with byte enables. It sign- or zero-extends load data and stalls the control unit via `busy` until the bus completes. It flags misaligned, illegal-funct3 and timed-out accesses.

## Interface
- `TIMEOUT`, 255: maximum cycles spent waiting for `m_ready` before aborting; legal range 1..255.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request strobe; sampled only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
- `req_addr` in 32: byte address (ALU result register).
- `req_wdata` in 32: store data (rs2 register), LSB-aligned.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid only with `done`; 1 = misaligned, illegal funct3 or timeout.
- `rdata` out 32: extended load result; holds its value until the next `done`.
- `m_valid` out 1: bus request.
- `m_we` out 1: bus write.
- `m_addr` out 32: word address, equal to `{req_addr[31:2],2'b00}`.
- `m_wdata` out 32: lane-replicated store data.
- `m_be` out 4: byte enables; 0000 on loads.
- `m_ready` in 1: bus acknowledge; for loads, `m_rdata` is valid in the same cycle.
- `m_rdata` in 32: bus read word.

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**, `req_valid`=1:
  - Latch `we`, `funct3`, `addr[1:0]` and the `m_*` request fields.
  - Misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0. Illegal funct3: loads 3/6/7, stores ≥3. Either case goes to RESP with an error flag; no bus cycle is issued.
  - Otherwise go to ACCESS and clear the timeout counter.
- **ACCESS**:
  - `m_valid`=1. All `m_*` outputs stay stable until the handshake.
  - `m_ready`=1: capture the extended load data (loads only) and go to RESP with err=0.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, go to RESP with err=1.
- **RESP**: `done`=1 for exactly one cycle; `err` is driven from the flag; next state is IDLE.
- `rdata` update rules:
  - Written on `done` of a successful load.
  - Set to 0 on `done` of an errored load.
  - Unchanged by stores.
- Store lane mapping (lane = addr[1:0]):
  - SB: `m_wdata`={4{wdata[7:0]}}, `m_be`=0001<<lane.
  - SH: `m_wdata`={2{wdata[15:0]}}, `m_be`=0011 (lane 0) or 1100 (lane 2).
  - SW: `m_wdata`=wdata, `m_be`=1111.
- Load extraction: byte = m_rdata[8·lane+7 : 8·lane]; half = m_rdata[16·lane[1]+15 : 16·lane[1]]. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- `req_valid` is ignored while `busy`=1; no queuing.

## Timing
- Reset (asynchronous, any state): state=IDLE, counter=0. `busy`, `done`, `err`, `m_valid`, `m_we`=0; `m_be`=0000; `rdata`, `m_addr`, `m_wdata`=0. Reset during ACCESS drops `m_valid` without waiting for a clock edge.
- Zero-wait access: request accepted at edge 0 → ACCESS during cycle 1 with `m_ready`=1 → `done` during cycle 2. Minimum latency is 2 cycles.
- With N cycles of `m_ready`=0, latency is 2+N cycles.
- Error without a bus cycle: `done`/`err` in the cycle right after acceptance (latency 1).
- Timeout: `m_valid` is held for exactly `TIMEOUT` cycles, then deasserts; `done`/`err` follow in the next cycle. If `m_ready` arrives in the same cycle the counter would reach `TIMEOUT`, the handshake wins (err=0).
- Back-to-back: IDLE lasts at least one cycle after RESP, so the next request can be accepted in the cycle after `done`.

## Test plan
- LW at 0x100, bus returns 0xDEADBEEF with zero wait → `m_be`=0000, `m_addr`=0x100, `done` 2 cycles after acceptance, `rdata`=0xDEADBEEF, err=0.
- LB at 0x103, 3 wait cycles, bus word 0x80112233 → `done` at latency 5, `rdata`=0xFFFFFF80. Repeat as LBU → `rdata`=0x00000080.
- SH at 0x102 with wdata 0x0000ABCD → `m_addr`=0x100, `m_wdata`=0xABCDABCD, `m_be`=1100, `m_we`=1, `rdata` unchanged.
- LW at 0x101, and separately funct3=3 load at 0x100 → no `m_valid`, `done`+`err` after 1 cycle, `rdata`=0.
- TIMEOUT=4 with `m_ready` held low → `m_valid` high for 4 cycles, then `done`+`err`. Second run with `m_ready` rising in the 4th cycle → err=0.
- Pulse `req_valid` during ACCESS, and assert `rst` low mid-ACCESS → the extra request is ignored; on reset all outputs go to 0 immediately and the next request after reset release completes normally.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: one request per access, store lane alignment, load extension,
// and a valid/ready data-memory handshake with misalignment, illegal-funct3 and timeout errors.
module riscv_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nx;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        err_q;
  logic [7:0]  cnt;

  logic        req_bad;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        cnt_hit;

  // Request decode: error classification and store lane placement.
  always_comb begin
    req_bad  = 1'b0;
    st_wdata = '0;
    st_be    = '0;
    if (req_we) req_bad = (req_funct3 >= 3'd3);
    else        req_bad = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    case (req_funct3[1:0])
      2'd1:    if (req_addr[0]) req_bad = 1'b1;
      2'd2:    if (req_addr[1:0] != 2'b00) req_bad = 1'b1;
      default: ;
    endcase
    if (req_we) begin
      case (req_funct3[1:0])
        2'd0: begin
          st_wdata = {4{req_wdata[7:0]}};
          st_be    = 4'b0001 << req_addr[1:0];
        end
        2'd1: begin
          st_wdata = {2{req_wdata[15:0]}};
          st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          st_wdata = req_wdata;
          st_be    = 4'b1111;
        end
      endcase
    end
  end

  // Load extraction from the bus word using the latched lane and width.
  always_comb begin
    ld_byte = '0;
    case (lane_q)
      2'd0: ld_byte = m_rdata[7:0];
      2'd1: ld_byte = m_rdata[15:8];
      2'd2: ld_byte = m_rdata[23:16];
      2'd3: ld_byte = m_rdata[31:24];
      default: ;
    endcase
    ld_half = lane_q[1] ? m_rdata[31:16] : m_rdata[15:0];
    case (f3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = m_rdata;
    endcase
  end

  assign cnt_hit = ((32'(cnt) + 32'd1) == TIMEOUT);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = req_bad ? RESP : ACCESS;
      ACCESS:  if (m_ready || cnt_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f3_q    <= '0;
      lane_q  <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
      rdata   <= '0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          f3_q    <= req_funct3;
          lane_q  <= req_addr[1:0];
          err_q   <= req_bad;
          cnt     <= '0;
          m_we    <= req_we;
          m_addr  <= {req_addr[31:2], 2'b00};
          m_wdata <= st_wdata;
          m_be    <= st_be;
          if (req_bad && !req_we) rdata <= '0;
        end
        ACCESS: begin
          if (m_ready) begin
            err_q <= 1'b0;
            if (!m_we) rdata <= ld_data;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt_hit) begin
              err_q <= 1'b1;
              if (!m_we) rdata <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign m_valid = (state == ACCESS);
  assign done    = (state == RESP);
  assign err     = done & err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: table of access vectors plus hand sequences for
// request-while-busy and reset during a bus access.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, done, err, m_valid, m_we;
  logic [31:0] rdata, m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus;
    int          wait_n;
    logic        exp_err;
    int          exp_lat;
    int          exp_mv;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int mv;
    bit finished;
    lat = 0;
    mv = 0;
    finished = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    m_ready    = 1'b0;
    m_rdata    = v.bus;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 40 && !finished; c++) begin
      @(negedge clk);
      lat++;
      m_ready = 1'b0;
      if (m_valid) begin
        mv++;
        chk($sformatf("v%0d m_addr", idx), m_addr, v.addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d m_be", idx), {28'd0, m_be}, {28'd0, v.exp_be});
        chk($sformatf("v%0d m_we", idx), {31'd0, m_we}, {31'd0, v.we});
        if (v.we) chk($sformatf("v%0d m_wdata", idx), m_wdata, v.exp_wdata);
        if (mv > v.wait_n) m_ready = 1'b1;
      end
      if (done) begin
        finished = 1;
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
        chk($sformatf("v%0d m_valid cycles", idx), mv, v.exp_mv);
      end
    end
    m_ready = 1'b0;
    if (!finished) chk($sformatf("v%0d done within bound", idx), 32'd0, 32'd1);
  endtask

  initial begin
    //        we  f3  addr          wdata         bus           wait err lat mv rdata         be       wdata
    vecs[0]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0,   1'b0, 2, 1, 32'hDEADBEEF, 4'b0000, 32'h0};
    vecs[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'h80112233, 3,   1'b0, 5, 4, 32'hFFFFFF80, 4'b0000, 32'h0};
    vecs[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h80112233, 3,   1'b0, 5, 4, 32'h00000080, 4'b0000, 32'h0};
    vecs[3]  = '{1'b1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0,        0,   1'b0, 2, 1, 32'h00000080, 4'b1100, 32'hABCDABCD};
    vecs[4]  = '{1'b1, 3'd0, 32'h101, 32'h12345678, 32'h0,        1,   1'b0, 3, 2, 32'h00000080, 4'b0010, 32'h78787878};
    vecs[5]  = '{1'b1, 3'd2, 32'h100, 32'hCAFEBABE, 32'h0,        0,   1'b0, 2, 1, 32'h00000080, 4'b1111, 32'hCAFEBABE};
    vecs[6]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h80017FFF, 0,   1'b0, 2, 1, 32'hFFFF8001, 4'b0000, 32'h0};
    vecs[7]  = '{1'b0, 3'd5, 32'h100, 32'h0,        32'h8001F00F, 2,   1'b0, 4, 3, 32'h0000F00F, 4'b0000, 32'h0};
    vecs[8]  = '{1'b1, 3'd1, 32'h101, 32'h1111,     32'h0,        0,   1'b1, 1, 0, 32'h0000F00F, 4'b0000, 32'h0};
    vecs[9]  = '{1'b1, 3'd3, 32'h100, 32'h1111,     32'h0,        0,   1'b1, 1, 0, 32'h0000F00F, 4'b0000, 32'h0};
    vecs[10] = '{1'b0, 3'd2, 32'h101, 32'h0,        32'h55555555, 0,   1'b1, 1, 0, 32'h00000000, 4'b0000, 32'h0};
    vecs[11] = '{1'b0, 3'd3, 32'h100, 32'h0,        32'h55555555, 0,   1'b1, 1, 0, 32'h00000000, 4'b0000, 32'h0};
    vecs[12] = '{1'b0, 3'd2, 32'h200, 32'h0,        32'h77777777, 100, 1'b1, 5, 4, 32'h00000000, 4'b0000, 32'h0};
    vecs[13] = '{1'b0, 3'd2, 32'h204, 32'h0,        32'h12345678, 3,   1'b0, 5, 4, 32'h12345678, 4'b0000, 32'h0};

    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset m_valid", {31'd0, m_valid}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset m_addr", m_addr, 32'd0);
    chk("reset m_be", {28'd0, m_be}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Request pulsed while ACCESS is in progress must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300; m_rdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("busy pulse m_valid c1", {31'd0, m_valid}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h400; req_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy pulse m_addr", m_addr, 32'h300);
    chk("busy pulse m_we", {31'd0, m_we}, 32'd0);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("busy pulse done", {31'd0, done}, 32'd1);
    chk("busy pulse rdata", rdata, 32'hA5A5A5A5);
    @(negedge clk);
    chk("busy pulse idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("busy pulse no second access", {31'd0, m_valid | busy}, 32'd0);

    // Reset asserted mid-ACCESS clears outputs without a clock edge.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h501; req_wdata = 32'h000000EE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset m_valid", {31'd0, m_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async reset m_valid", {31'd0, m_valid}, 32'd0);
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset m_we", {31'd0, m_we}, 32'd0);
    chk("async reset m_addr", m_addr, 32'd0);
    chk("async reset m_wdata", m_wdata, 32'd0);
    chk("async reset m_be", {28'd0, m_be}, 32'd0);
    chk("async reset rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(100, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global time limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
